idex_stage: RTL and testbench

ID/EX pipeline stage for the 8-bit MIPS-style core. It captures decoded operands from IF/ID, register-file read data and write-back data into the ID/EX register. It computes the FORWARD_A/FORWARD_B codes one cycle ahead, so the ALU receives them registered. It also handles pipeline hold, branch flush and, optionally, load-use bubbles.

---
 rtl/idex_pkg.sv | 41 ++++
 rtl/idex_stage_fwd_select.sv | 33 +++
 rtl/idex_stage.sv | 143 ++++++++++++++
 tb/tb_idex_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/idex_pkg.sv
// Shared encodings for the ID/EX stage: instruction classes, operand forward
// codes and the ALU opcode set.
package idex_pkg;

  typedef enum logic [1:0] {
    CLS_NONE = 2'b00,
    CLS_ALU  = 2'b01,
    CLS_LOAD = 2'b10,
    CLS_IMM  = 2'b11
  } instr_class_e;

  // Bit 2 selects the MEM-stage producer, bits 1:0 the kind of value forwarded.
  localparam logic [2:0] FWD_NONE     = 3'b000;
  localparam logic [2:0] FWD_EX_IMM   = 3'b001;
  localparam logic [2:0] FWD_EX_LOAD  = 3'b010;
  localparam logic [2:0] FWD_EX_ALU   = 3'b011;
  localparam logic [2:0] FWD_MEM_IMM  = 3'b101;
  localparam logic [2:0] FWD_MEM_LOAD = 3'b110;
  localparam logic [2:0] FWD_MEM_ALU  = 3'b111;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_XOR = 5'h05;
  localparam logic [4:0] OP_LDI = 5'h10;
  localparam logic [4:0] OP_LD  = 5'h11;

  function automatic logic [2:0] fwd_code_for(input logic [1:0] cls, input logic mem_stage);
    logic [2:0] code;
    case (instr_class_e'(cls))
      CLS_ALU:  code = mem_stage ? FWD_MEM_ALU  : FWD_EX_ALU;
      CLS_LOAD: code = mem_stage ? FWD_MEM_LOAD : FWD_EX_LOAD;
      CLS_IMM:  code = mem_stage ? FWD_MEM_IMM  : FWD_EX_IMM;
      default:  code = FWD_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/idex_stage_fwd_select.sv
// Combinational forward-code selection for one source operand; the instruction
// currently in EX takes priority over the one in MEM.
module fwd_select
  import idex_pkg::*;
(
  input  logic [3:0] src_addr,
  input  logic       use_src,
  input  logic       idex_valid,
  input  logic [1:0] idex_class,
  input  logic [3:0] idex_dest_addr,
  input  logic       exmem_valid,
  input  logic [1:0] exmem_class,
  input  logic [3:0] exmem_dest_addr,
  output logic [2:0] fwd_code
);

  logic near_match;
  logic far_match;

  always_comb begin
    near_match = use_src && idex_valid && (idex_class != CLS_NONE) &&
                 (idex_dest_addr == src_addr);
    far_match  = use_src && exmem_valid && (exmem_class != CLS_NONE) &&
                 (exmem_dest_addr == src_addr);
    fwd_code   = FWD_NONE;
    if (near_match) begin
      fwd_code = fwd_code_for(idex_class, 1'b0);
    end else if (far_match) begin
      fwd_code = fwd_code_for(exmem_class, 1'b1);
    end
  end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with registered forward selects, write-back bypass,
// hold/flush handling and an optional one-bubble load-use interlock.
module idex_stage
  import idex_pkg::*;
#(
  parameter bit LOAD_USE_STALL = 1'b0,
  parameter int DATA_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              ifid_valid,
  input  logic [4:0]        ifid_opcode,
  input  logic [1:0]        ifid_class,
  input  logic [3:0]        ifid_r1_addr,
  input  logic [3:0]        ifid_r2_addr,
  input  logic [3:0]        ifid_dest_addr,
  input  logic              ifid_use_r1,
  input  logic              ifid_use_r2,
  input  logic [DATA_W-1:0] rf_r1_data,
  input  logic [DATA_W-1:0] rf_r2_data,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              exmem_valid,
  input  logic [1:0]        exmem_class,
  input  logic [3:0]        exmem_dest_addr,
  output logic              idex_valid,
  output logic [4:0]        idex_opcode,
  output logic [1:0]        idex_class,
  output logic [3:0]        idex_r1_addr,
  output logic [3:0]        idex_r2_addr,
  output logic [3:0]        idex_dest_addr,
  output logic [DATA_W-1:0] idex_r1_data,
  output logic [DATA_W-1:0] idex_r2_data,
  output logic [2:0]        forward_a,
  output logic [2:0]        forward_b,
  output logic              stall_out
);

  logic              valid_reg;
  logic [4:0]        opcode_reg;
  logic [1:0]        class_reg;
  logic [3:0]        r1_addr_reg;
  logic [3:0]        r2_addr_reg;
  logic [3:0]        dest_reg;
  logic [DATA_W-1:0] r1_data_reg;
  logic [DATA_W-1:0] r2_data_reg;
  logic [2:0]        fwd_a_reg;
  logic [2:0]        fwd_b_reg;

  logic [1:0][3:0]        src_addr;
  logic [1:0]             use_src;
  logic [1:0][DATA_W-1:0] rf_data;
  logic [1:0][DATA_W-1:0] opnd_next;
  logic [1:0][2:0]        fwd_next;
  logic                   load_use;
  logic                   advance;
  logic                   slot_live;

  assign src_addr = {ifid_r2_addr, ifid_r1_addr};
  assign use_src  = {ifid_use_r2, ifid_use_r1};
  assign rf_data  = {rf_r2_data, rf_r1_data};

  // The write-back bypass only matters when no younger producer is forwarded.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      fwd_select u_fwd_select (
        .src_addr        (src_addr[gi]),
        .use_src         (use_src[gi]),
        .idex_valid      (valid_reg),
        .idex_class      (class_reg),
        .idex_dest_addr  (dest_reg),
        .exmem_valid     (exmem_valid),
        .exmem_class     (exmem_class),
        .exmem_dest_addr (exmem_dest_addr),
        .fwd_code        (fwd_next[gi])
      );

      assign opnd_next[gi] = (fwd_next[gi] == FWD_NONE && wb_en && wb_addr == src_addr[gi])
                             ? wb_data : rf_data[gi];
    end
  endgenerate

  // A near LOAD match means the data is not ready yet; wait one cycle for MEM.
  generate
    if (LOAD_USE_STALL) begin : g_stall
      assign load_use = !hold && (fwd_next[0] == FWD_EX_LOAD || fwd_next[1] == FWD_EX_LOAD);
    end else begin : g_no_stall
      assign load_use = 1'b0;
    end
  endgenerate

  assign advance   = !hold && !load_use;
  assign slot_live = ifid_valid && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      opcode_reg  <= '0;
      class_reg   <= CLS_NONE;
      r1_addr_reg <= '0;
      r2_addr_reg <= '0;
      dest_reg    <= '0;
      r1_data_reg <= '0;
      r2_data_reg <= '0;
      fwd_a_reg   <= FWD_NONE;
      fwd_b_reg   <= FWD_NONE;
    end else if (advance) begin
      valid_reg   <= slot_live;
      opcode_reg  <= ifid_opcode;
      class_reg   <= slot_live ? ifid_class : CLS_NONE;
      r1_addr_reg <= ifid_r1_addr;
      r2_addr_reg <= ifid_r2_addr;
      dest_reg    <= ifid_dest_addr;
      r1_data_reg <= opnd_next[0];
      r2_data_reg <= opnd_next[1];
      fwd_a_reg   <= slot_live ? fwd_next[0] : FWD_NONE;
      fwd_b_reg   <= slot_live ? fwd_next[1] : FWD_NONE;
    end else if (!hold) begin
      // load-use bubble: EX becomes empty while IF/ID holds its instruction
      valid_reg   <= 1'b0;
      class_reg   <= CLS_NONE;
      fwd_a_reg   <= FWD_NONE;
      fwd_b_reg   <= FWD_NONE;
    end
  end

  assign idex_valid     = valid_reg;
  assign idex_opcode    = opcode_reg;
  assign idex_class     = class_reg;
  assign idex_r1_addr   = r1_addr_reg;
  assign idex_r2_addr   = r2_addr_reg;
  assign idex_dest_addr = dest_reg;
  assign idex_r1_data   = r1_data_reg;
  assign idex_r2_data   = r2_data_reg;
  assign forward_a      = fwd_a_reg;
  assign forward_b      = fwd_b_reg;
  assign stall_out      = load_use;

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: a stalling and a non-stalling instance share
// stimulus; expected EX contents go through a scoreboard queue.
module tb_idex_stage;
  import idex_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, hold, flush, ifid_valid;
  logic [4:0] ifid_opcode;
  logic [1:0] ifid_class;
  logic [3:0] ifid_r1_addr, ifid_r2_addr, ifid_dest_addr;
  logic       ifid_use_r1, ifid_use_r2;
  logic [7:0] rf_r1_data, rf_r2_data;
  logic       wb_en;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;
  logic       exmem_valid;
  logic [1:0] exmem_class;
  logic [3:0] exmem_dest_addr;

  logic       s_valid, n_valid, s_stall, n_stall;
  logic [4:0] s_opcode, n_opcode;
  logic [1:0] s_class, n_class;
  logic [3:0] s_r1a, s_r2a, s_dest, n_r1a, n_r2a, n_dest;
  logic [7:0] s_r1d, s_r2d, n_r1d, n_r2d;
  logic [2:0] s_fa, s_fb, n_fa, n_fb;

  typedef struct {
    logic       valid;
    logic [1:0] cls;
    logic [4:0] op;
    logic [3:0] dest;
    logic [2:0] fa;
    logic [2:0] fb;
    logic [7:0] r1d;
    logic [7:0] r2d;
    bit         full;
  } exp_t;

  exp_t sb_q[$];
  exp_t prev_ex;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  idex_stage #(.LOAD_USE_STALL(1'b1), .DATA_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .ifid_valid(ifid_valid), .ifid_opcode(ifid_opcode), .ifid_class(ifid_class),
    .ifid_r1_addr(ifid_r1_addr), .ifid_r2_addr(ifid_r2_addr), .ifid_dest_addr(ifid_dest_addr),
    .ifid_use_r1(ifid_use_r1), .ifid_use_r2(ifid_use_r2),
    .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exmem_valid(exmem_valid), .exmem_class(exmem_class), .exmem_dest_addr(exmem_dest_addr),
    .idex_valid(s_valid), .idex_opcode(s_opcode), .idex_class(s_class),
    .idex_r1_addr(s_r1a), .idex_r2_addr(s_r2a), .idex_dest_addr(s_dest),
    .idex_r1_data(s_r1d), .idex_r2_data(s_r2d),
    .forward_a(s_fa), .forward_b(s_fb), .stall_out(s_stall)
  );

  idex_stage #(.LOAD_USE_STALL(1'b0), .DATA_W(8)) u_nostall (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .ifid_valid(ifid_valid), .ifid_opcode(ifid_opcode), .ifid_class(ifid_class),
    .ifid_r1_addr(ifid_r1_addr), .ifid_r2_addr(ifid_r2_addr), .ifid_dest_addr(ifid_dest_addr),
    .ifid_use_r1(ifid_use_r1), .ifid_use_r2(ifid_use_r2),
    .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exmem_valid(exmem_valid), .exmem_class(exmem_class), .exmem_dest_addr(exmem_dest_addr),
    .idex_valid(n_valid), .idex_opcode(n_opcode), .idex_class(n_class),
    .idex_r1_addr(n_r1a), .idex_r2_addr(n_r2a), .idex_dest_addr(n_dest),
    .idex_r1_data(n_r1d), .idex_r2_data(n_r2d),
    .forward_a(n_fa), .forward_b(n_fb), .stall_out(n_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [1:0] c, input logic [4:0] op,
                              input logic [3:0] d, input logic [2:0] fa, input logic [2:0] fb,
                              input logic [7:0] r1d, input logic [7:0] r2d, input bit full);
    exp_t e;
    e.valid = v; e.cls = c; e.op = op; e.dest = d;
    e.fa = fa; e.fb = fb; e.r1d = r1d; e.r2d = r2d; e.full = full;
    return e;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] op, input logic [1:0] c,
                        input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] d,
                        input logic u1, input logic u2, input logic [7:0] d1, input logic [7:0] d2);
    ifid_valid = v; ifid_opcode = op; ifid_class = c;
    ifid_r1_addr = r1; ifid_r2_addr = r2; ifid_dest_addr = d;
    ifid_use_r1 = u1; ifid_use_r2 = u2; rf_r1_data = d1; rf_r2_data = d2;
  endtask

  // One clock of the stalling instance; 'shift' moves the old EX entry into MEM.
  task automatic step(input string tag, input exp_t e, input bit shift);
    exp_t got;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".valid"}, 32'(s_valid), 32'(got.valid));
    chk({tag, ".class"}, 32'(s_class), 32'(got.cls));
    chk({tag, ".fwd_a"}, 32'(s_fa), 32'(got.fa));
    chk({tag, ".fwd_b"}, 32'(s_fb), 32'(got.fb));
    if (got.full) begin
      chk({tag, ".opcode"}, 32'(s_opcode), 32'(got.op));
      chk({tag, ".dest"}, 32'(s_dest), 32'(got.dest));
      chk({tag, ".r1_data"}, 32'(s_r1d), 32'(got.r1d));
      chk({tag, ".r2_data"}, 32'(s_r2d), 32'(got.r2d));
    end
    if (shift) begin
      exmem_valid = prev_ex.valid;
      exmem_class = prev_ex.cls;
      exmem_dest_addr = prev_ex.dest;
      prev_ex = got;
    end
    $display("step %s: valid=%0d class=%0d fwd_a=%03b fwd_b=%03b r1=%02h r2=%02h",
             tag, s_valid, s_class, s_fa, s_fb, s_r1d, s_r2d);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, 32'(s_valid), 32'd0);
    chk({tag, ".opcode"}, 32'(s_opcode), 32'd0);
    chk({tag, ".class"}, 32'(s_class), 32'd0);
    chk({tag, ".r1_addr"}, 32'(s_r1a), 32'd0);
    chk({tag, ".r2_addr"}, 32'(s_r2a), 32'd0);
    chk({tag, ".dest"}, 32'(s_dest), 32'd0);
    chk({tag, ".r1_data"}, 32'(s_r1d), 32'd0);
    chk({tag, ".r2_data"}, 32'(s_r2d), 32'd0);
    chk({tag, ".fwd_a"}, 32'(s_fa), 32'd0);
    chk({tag, ".fwd_b"}, 32'(s_fb), 32'd0);
    chk({tag, ".stall"}, 32'(s_stall), 32'd0);
    chk({tag, ".ns_valid"}, 32'(n_valid), 32'd0);
    chk({tag, ".ns_fwd_b"}, 32'(n_fb), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    set_id(1'b0, OP_NOP, CLS_NONE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00);
    exmem_valid = 1'b0; exmem_class = CLS_NONE; exmem_dest_addr = '0;
    prev_ex = mk(1'b0, CLS_NONE, OP_NOP, 4'd0, 3'b000, 3'b000, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    rst_n = 1'b0;
    #2;
    chk_reset("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ALU, one-gap ALU, newest producer, unused operands
    set_id(1, OP_ADD, CLS_ALU, 4'd1, 4'd2, 4'd3, 1, 1, 8'h11, 8'h22);
    step("add_r3", mk(1, CLS_ALU, OP_ADD, 4'd3, 3'b000, 3'b000, 8'h11, 8'h22, 1), 1);
    set_id(1, OP_SUB, CLS_ALU, 4'd3, 4'd1, 4'd4, 1, 1, 8'h33, 8'h11);
    step("sub_near", mk(1, CLS_ALU, OP_SUB, 4'd4, 3'b011, 3'b000, 8'h33, 8'h11, 1), 1);
    set_id(1, OP_OR, CLS_ALU, 4'd11, 4'd12, 4'd10, 1, 1, 8'h0B, 8'h0C);
    step("or_indep", mk(1, CLS_ALU, OP_OR, 4'd10, 3'b000, 3'b000, 8'h0B, 8'h0C, 1), 1);
    set_id(1, OP_XOR, CLS_ALU, 4'd4, 4'd3, 4'd13, 1, 1, 8'h44, 8'h33);
    step("xor_far", mk(1, CLS_ALU, OP_XOR, 4'd13, 3'b111, 3'b000, 8'h44, 8'h33, 1), 1);
    set_id(1, OP_ADD, CLS_ALU, 4'd13, 4'd10, 4'd13, 1, 1, 8'hD0, 8'h0A);
    step("add_near_far", mk(1, CLS_ALU, OP_ADD, 4'd13, 3'b011, 3'b111, 8'hD0, 8'h0A, 1), 1);
    set_id(1, OP_SUB, CLS_ALU, 4'd13, 4'd13, 4'd14, 1, 1, 8'hD1, 8'hD2);
    step("newest_wins", mk(1, CLS_ALU, OP_SUB, 4'd14, 3'b011, 3'b011, 8'hD1, 8'hD2, 1), 1);
    set_id(1, OP_AND, CLS_ALU, 4'd13, 4'd13, 4'd15, 0, 0, 8'hE1, 8'hE2);
    step("unused_src", mk(1, CLS_ALU, OP_AND, 4'd15, 3'b000, 3'b000, 8'hE1, 8'hE2, 1), 1);

    // Asynchronous reset with a valid instruction in EX, no clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("reset_mid");
    do_reset();

    // Immediate chain
    set_id(1, OP_LDI, CLS_IMM, 4'd2, 4'hA, 4'd5, 0, 0, 8'h02, 8'h0A);
    step("ldi_r5", mk(1, CLS_IMM, OP_LDI, 4'd5, 3'b000, 3'b000, 8'h02, 8'h0A, 1), 1);
    set_id(1, OP_AND, CLS_ALU, 4'd5, 4'd2, 4'd6, 1, 1, 8'h55, 8'h22);
    step("imm_near", mk(1, CLS_ALU, OP_AND, 4'd6, 3'b001, 3'b000, 8'h55, 8'h22, 1), 1);
    set_id(1, OP_LDI, CLS_IMM, 4'd1, 4'd3, 4'd5, 0, 0, 8'h01, 8'h03);
    step("ldi_r5b", mk(1, CLS_IMM, OP_LDI, 4'd5, 3'b000, 3'b000, 8'h01, 8'h03, 1), 1);
    set_id(1, OP_OR, CLS_ALU, 4'd8, 4'd9, 4'd7, 1, 1, 8'h88, 8'h99);
    step("imm_gap", mk(1, CLS_ALU, OP_OR, 4'd7, 3'b000, 3'b000, 8'h88, 8'h99, 1), 1);
    set_id(1, OP_AND, CLS_ALU, 4'd5, 4'd2, 4'd6, 1, 1, 8'h55, 8'h22);
    step("imm_far", mk(1, CLS_ALU, OP_AND, 4'd6, 3'b101, 3'b000, 8'h55, 8'h22, 1), 1);
    set_id(0, OP_ADD, CLS_ALU, 4'd6, 4'd7, 4'd1, 1, 1, 8'h66, 8'h77);
    step("invalid_slot", mk(0, CLS_NONE, OP_NOP, 4'd0, 3'b000, 3'b000, 8'h00, 8'h00, 0), 1);

    // Load-use
    do_reset();
    set_id(1, OP_LD, CLS_LOAD, 4'd1, 4'd0, 4'd7, 1, 0, 8'h01, 8'h00);
    step("ld_r7", mk(1, CLS_LOAD, OP_LD, 4'd7, 3'b000, 3'b000, 8'h01, 8'h00, 1), 1);
    chk("ld_r7.ns_class", 32'(n_class), 32'(CLS_LOAD));
    hold = 1'b1;
    set_id(1, OP_ADD, CLS_ALU, 4'd2, 4'd7, 4'd8, 1, 1, 8'h22, 8'h77);
    #1;
    chk("lu_hold.stall", 32'(s_stall), 32'd0);
    step("lu_hold", mk(1, CLS_LOAD, OP_LD, 4'd7, 3'b000, 3'b000, 8'h01, 8'h00, 1), 0);
    hold = 1'b0;
    #1;
    chk("lu_detect.stall", 32'(s_stall), 32'd1);
    chk("lu_detect.ns_stall", 32'(n_stall), 32'd0);
    step("lu_bubble", mk(0, CLS_NONE, OP_NOP, 4'd0, 3'b000, 3'b000, 8'h00, 8'h00, 0), 1);
    chk("lu_nostall.valid", 32'(n_valid), 32'd1);
    chk("lu_nostall.fwd_a", 32'(n_fa), 32'b000);
    chk("lu_nostall.fwd_b", 32'(n_fb), 32'b010);
    #1;
    chk("lu_release.stall", 32'(s_stall), 32'd0);
    step("lu_fwd", mk(1, CLS_ALU, OP_ADD, 4'd8, 3'b000, 3'b110, 8'h22, 8'h77, 1), 1);
    set_id(1, OP_LD, CLS_LOAD, 4'd1, 4'd0, 4'd7, 1, 0, 8'h01, 8'h00);
    step("ld_r7b", mk(1, CLS_LOAD, OP_LD, 4'd7, 3'b000, 3'b000, 8'h01, 8'h00, 1), 1);
    flush = 1'b1;
    set_id(1, OP_ADD, CLS_ALU, 4'd7, 4'd7, 4'd9, 1, 1, 8'h77, 8'h77);
    #1;
    chk("lu_flush.stall", 32'(s_stall), 32'd1);
    step("lu_flush", mk(0, CLS_NONE, OP_NOP, 4'd0, 3'b000, 3'b000, 8'h00, 8'h00, 0), 1);
    flush = 1'b0;
    set_id(0, OP_NOP, CLS_NONE, 4'd0, 4'd0, 4'd0, 0, 0, 8'h00, 8'h00);
    #1;
    chk("lu_flush_drop.stall", 32'(s_stall), 32'd0);
    step("lu_flush_idle", mk(0, CLS_NONE, OP_NOP, 4'd0, 3'b000, 3'b000, 8'h00, 8'h00, 0), 1);

    // Write-back bypass, including register 0 and suppression under forwarding
    do_reset();
    wb_en = 1'b1; wb_addr = 4'd9; wb_data = 8'h5C;
    set_id(1, OP_OR, CLS_ALU, 4'd9, 4'd0, 4'd2, 1, 1, 8'h00, 8'h44);
    step("wb_r9", mk(1, CLS_ALU, OP_OR, 4'd2, 3'b000, 3'b000, 8'h5C, 8'h44, 1), 1);
    wb_addr = 4'd0; wb_data = 8'hA5;
    set_id(1, OP_ADD, CLS_ALU, 4'd1, 4'd0, 4'd3, 1, 1, 8'h10, 8'h00);
    step("wb_r0", mk(1, CLS_ALU, OP_ADD, 4'd3, 3'b000, 3'b000, 8'h10, 8'hA5, 1), 1);
    wb_addr = 4'd3; wb_data = 8'h99;
    set_id(1, OP_SUB, CLS_ALU, 4'd3, 4'd5, 4'd4, 1, 1, 8'h31, 8'h55);
    step("wb_shadowed", mk(1, CLS_ALU, OP_SUB, 4'd4, 3'b011, 3'b000, 8'h31, 8'h55, 1), 1);
    wb_en = 1'b0;

    // Hold with flush pending, then flush on release
    hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, OP_ADD, CLS_ALU, 4'd4, 4'd4, 4'd5, 1, 1, 8'(8'hE0 + i), 8'hEE);
      #1;
      chk("hold.stall", 32'(s_stall), 32'd0);
      step("hold", mk(1, CLS_ALU, OP_SUB, 4'd4, 3'b011, 3'b000, 8'h31, 8'h55, 1), 0);
    end
    hold = 1'b0;
    step("flush", mk(0, CLS_NONE, OP_NOP, 4'd0, 3'b000, 3'b000, 8'h00, 8'h00, 0), 1);
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
